// File: rtl/axis_weight_sched_pkg.sv
// Shared types and beat-count arithmetic for the weight-rotator layer scheduler.
package axis_weight_sched_pkg;

  localparam int unsigned BEATS_CONFIG_3X3_1 = 20;
  localparam int unsigned BEATS_CONFIG_1X1_1 = 12;
  localparam int unsigned BITS_W_BEATS       = 16;

  typedef enum logic [1:0] {
    L_IDLE,
    L_CALC,
    L_REQ,
    L_LOAD
  } l_state_t;

  typedef enum logic {
    R_IDLE,
    R_ROT
  } r_state_t;

  // One header beat, the config beats, one trailer beat, then the weight payload.
  function automatic int unsigned w_beats(input int unsigned k_1, input int unsigned cin_1,
                                          input int unsigned cfg_3x3_1,
                                          input int unsigned cfg_1x1_1);
    int unsigned cfg_1;
    cfg_1 = (k_1 == 0) ? cfg_1x1_1 : cfg_3x3_1;
    return 1 + cfg_1 + 1 + (k_1 + 1) * (cin_1 + 1);
  endfunction

endpackage

// File: rtl/axis_weight_sched_if.sv
// Command, DMA-request, rotator-tap and status bundle of axis_weight_sched.
interface axis_weight_sched_if #(
  parameter int unsigned KERNEL_H_MAX  = 3,
  parameter int unsigned IM_CIN_MAX    = 1024,
  parameter int unsigned IM_BLOCKS_MAX = 32,
  parameter int unsigned BITS_W_BEATS  = 16
);
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [$clog2(KERNEL_H_MAX)-1:0]  cmd_k_1;
  logic [$clog2(IM_CIN_MAX)-1:0]    cmd_cin_1;
  logic [$clog2(IM_BLOCKS_MAX)-1:0] cmd_blocks_1;
  logic                             dma_req_valid;
  logic                             dma_req_ready;
  logic [BITS_W_BEATS-1:0]          dma_req_beats;
  logic                             w_s_tvalid;
  logic                             w_s_tready;
  logic                             w_s_tlast;
  logic                             w_s_en;
  logic                             w_m_tvalid;
  logic                             w_m_tready;
  logic                             w_m_tlast;
  logic                             layer_done;
  logic                             busy;
  logic                             err_beats;

  modport slave (
    input  cmd_valid, cmd_k_1, cmd_cin_1, cmd_blocks_1, dma_req_ready,
           w_s_tvalid, w_s_tready, w_s_tlast, w_m_tvalid, w_m_tready, w_m_tlast,
    output cmd_ready, dma_req_valid, dma_req_beats, w_s_en, layer_done, busy, err_beats
  );

  modport master (
    output cmd_valid, cmd_k_1, cmd_cin_1, cmd_blocks_1, dma_req_ready,
           w_s_tvalid, w_s_tready, w_s_tlast, w_m_tvalid, w_m_tready, w_m_tlast,
    input  cmd_ready, dma_req_valid, dma_req_beats, w_s_en, layer_done, busy, err_beats
  );
endinterface

// File: rtl/weight_sched_rot_cnt.sv
// Rotate FSM: counts rotator output passes of the loaded layer and pulses layer_done.
module weight_sched_rot_cnt
  import axis_weight_sched_pkg::*;
#(
  parameter int unsigned BW = 5
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          load_rdy,
  input  logic [BW-1:0] pend_blocks_1,
  input  logic          m_last_hs,
  output logic          layer_done,
  output logic          idle
);

  r_state_t      state;
  logic [BW-1:0] rot_cnt;

  assign idle = (state == R_IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= R_IDLE;
      rot_cnt    <= '0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      unique case (state)
        R_IDLE: begin
          if (load_rdy) begin
            rot_cnt <= pend_blocks_1;
            state   <= R_ROT;
          end
        end
        R_ROT: begin
          if (m_last_hs) begin
            if (rot_cnt == '0) begin
              layer_done <= 1'b1;
              state      <= R_IDLE;
            end else begin
              rot_cnt <= rot_cnt - 1'b1;
            end
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axis_weight_sched.sv
// Layer scheduler for axis_weight_rotator: command intake, weights-DMA request, load gating.
// Optional WEIGHT_SCHED_PREFETCH_EN lets the next layer load while the current one rotates.
module axis_weight_sched
  import axis_weight_sched_pkg::*;
#(
  parameter int unsigned KERNEL_H_MAX       = 3,
  parameter int unsigned IM_CIN_MAX         = 1024,
  parameter int unsigned IM_BLOCKS_MAX      = 32,
  parameter int unsigned BEATS_CONFIG_3X3_1 = 20,
  parameter int unsigned BEATS_CONFIG_1X1_1 = 12,
  parameter int unsigned BITS_W_BEATS       = 16
) (
  input logic                aclk,
  input logic                aresetn,
  axis_weight_sched_if.slave bus
);

  localparam int unsigned KW = $clog2(KERNEL_H_MAX);
  localparam int unsigned CW = $clog2(IM_CIN_MAX);
  localparam int unsigned BW = $clog2(IM_BLOCKS_MAX);

  l_state_t                l_state;
  logic [KW-1:0]           k_1_q;
  logic [CW-1:0]           cin_1_q;
  logic [BW-1:0]           blocks_1_q;
  logic [BW-1:0]           pend_blocks_1;
  logic [BITS_W_BEATS-1:0] beat_cnt;
  logic [BITS_W_BEATS-1:0] beat_cnt_nxt;
  logic                    load_rdy;
  logic                    rot_idle;
  logic                    permit;
  logic                    cmd_hs;
  logic                    s_hs;
  logic                    m_last_hs;
  int unsigned             beats_full;

  logic                    cmd_ready_q;
  logic                    dma_req_valid_q;
  logic [BITS_W_BEATS-1:0] dma_req_beats_q;
  logic                    w_s_en_q;
  logic                    busy_q;
  logic                    err_beats_q;

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.dma_req_valid = dma_req_valid_q;
  assign bus.dma_req_beats = dma_req_beats_q;
  assign bus.w_s_en        = w_s_en_q;
  assign bus.busy          = busy_q;
  assign bus.err_beats     = err_beats_q;

`ifdef WEIGHT_SCHED_PREFETCH_EN
  assign permit = !load_rdy;
`else
  assign permit = !load_rdy && rot_idle;
`endif

  always_comb begin
    cmd_hs       = bus.cmd_valid && cmd_ready_q && (l_state == L_IDLE);
    s_hs         = bus.w_s_tvalid && bus.w_s_tready && (l_state == L_LOAD);
    m_last_hs    = bus.w_m_tvalid && bus.w_m_tready && bus.w_m_tlast;
    beat_cnt_nxt = beat_cnt + BITS_W_BEATS'(1);
    beats_full   = w_beats(32'(k_1_q), 32'(cin_1_q), BEATS_CONFIG_3X3_1, BEATS_CONFIG_1X1_1);
  end

  // cmd_ready/busy are registered from the current state, so they trail it by one cycle;
  // acceptance is also gated by L_IDLE so a stale ready can never double-accept.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      l_state         <= L_IDLE;
      k_1_q           <= '0;
      cin_1_q         <= '0;
      blocks_1_q      <= '0;
      pend_blocks_1   <= '0;
      beat_cnt        <= '0;
      load_rdy        <= 1'b0;
      cmd_ready_q     <= 1'b0;
      dma_req_valid_q <= 1'b0;
      dma_req_beats_q <= '0;
      w_s_en_q        <= 1'b0;
      busy_q          <= 1'b0;
      err_beats_q     <= 1'b0;
    end else begin
      cmd_ready_q <= (l_state == L_IDLE) && !cmd_hs && permit;
      busy_q      <= (l_state != L_IDLE) || load_rdy || !rot_idle;
      if (load_rdy && rot_idle) load_rdy <= 1'b0;

      unique case (l_state)
        L_IDLE: begin
          if (cmd_hs) begin
            k_1_q      <= bus.cmd_k_1;
            cin_1_q    <= bus.cmd_cin_1;
            blocks_1_q <= bus.cmd_blocks_1;
            l_state    <= L_CALC;
          end
        end
        L_CALC: begin
          dma_req_beats_q <= beats_full[BITS_W_BEATS-1:0];
          dma_req_valid_q <= 1'b1;
          l_state         <= L_REQ;
        end
        L_REQ: begin
          if (bus.dma_req_ready) begin
            dma_req_valid_q <= 1'b0;
            w_s_en_q        <= 1'b1;
            beat_cnt        <= '0;
            l_state         <= L_LOAD;
          end
        end
        L_LOAD: begin
          if (s_hs) begin
            beat_cnt <= beat_cnt_nxt;
            if (bus.w_s_tlast) begin
              if (beat_cnt_nxt != dma_req_beats_q) err_beats_q <= 1'b1;
              w_s_en_q      <= 1'b0;
              load_rdy      <= 1'b1;
              pend_blocks_1 <= blocks_1_q;
              l_state       <= L_IDLE;
            end
          end
        end
        default: l_state <= L_IDLE;
      endcase
    end
  end

  weight_sched_rot_cnt #(
    .BW(BW)
  ) u_rot_cnt (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .load_rdy      (load_rdy),
    .pend_blocks_1 (pend_blocks_1),
    .m_last_hs     (m_last_hs),
    .layer_done    (bus.layer_done),
    .idle          (rot_idle)
  );

endmodule

// File: tb/tb_axis_weight_sched.sv
// Directed bench for axis_weight_sched: table of layers plus serialization, coincidence and reset sequences.
module tb_axis_weight_sched;
  import axis_weight_sched_pkg::*;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_weight_sched_if #(
    .KERNEL_H_MAX(3), .IM_CIN_MAX(1024), .IM_BLOCKS_MAX(32), .BITS_W_BEATS(16)
  ) bus ();

  axis_weight_sched #(
    .KERNEL_H_MAX(3), .IM_CIN_MAX(1024), .IM_BLOCKS_MAX(32),
    .BEATS_CONFIG_3X3_1(20), .BEATS_CONFIG_1X1_1(12), .BITS_W_BEATS(16)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  typedef struct {
    int unsigned k_1;
    int unsigned cin_1;
    int unsigned blocks_1;
    int unsigned n_sent;
    int unsigned exp_beats;
    int unsigned exp_err;
  } vec_t;

  vec_t vecs[5];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_cmd(input int unsigned k, input int unsigned c, input int unsigned b);
    logic rdy;
    bit   done;
    done = 0;
    bus.cmd_k_1      = 2'(k);
    bus.cmd_cin_1    = 10'(c);
    bus.cmd_blocks_1 = 5'(b);
    bus.cmd_valid    = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      rdy = bus.cmd_ready;
      step();
      if (rdy) done = 1;
    end
    bus.cmd_valid = 1'b0;
    if (!done) timeout("cmd_accept");
  endtask

  task automatic take_req(input int unsigned exp_beats);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.dma_req_valid) seen = 1;
      else step();
    end
    if (!seen) timeout("dma_req");
    chk("req_beats", 32'(bus.dma_req_beats), exp_beats);
    bus.dma_req_ready = 1'b1;
    step();
    bus.dma_req_ready = 1'b0;
    chk("wsen_on", 32'(bus.w_s_en), 1);
  endtask

  task automatic send_beats(input int unsigned n, input bit with_last);
    for (int unsigned i = 0; i < n; i++) begin
      bus.w_s_tvalid = 1'b1;
      bus.w_s_tready = 1'b1;
      bus.w_s_tlast  = with_last && (i == n - 1);
      step();
    end
    bus.w_s_tvalid = 1'b0;
    bus.w_s_tready = 1'b0;
    bus.w_s_tlast  = 1'b0;
    if (with_last) chk("wsen_off", 32'(bus.w_s_en), 0);
  endtask

  task automatic rotate(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.w_m_tvalid = 1'b1;
      bus.w_m_tready = 1'b1;
      bus.w_m_tlast  = 1'b1;
      step();
      bus.w_m_tvalid = 1'b0;
      bus.w_m_tready = 1'b0;
      bus.w_m_tlast  = 1'b0;
      chk("layer_done", 32'(bus.layer_done), (i == n - 1) ? 1 : 0);
    end
    step();
    chk("done_pulse", 32'(bus.layer_done), 0);
    chk("busy_fall", 32'(bus.busy), 0);
  endtask

  task automatic run_layer(input vec_t v);
    do_cmd(v.k_1, v.cin_1, v.blocks_1);
    chk("req_early", 32'(bus.dma_req_valid), 0);
    step();
    chk("req_lat", 32'(bus.dma_req_valid), 1);
    chk("req_beats", 32'(bus.dma_req_beats), v.exp_beats);
    step();
    chk("req_hold", 32'(bus.dma_req_valid), 1);
    chk("req_hold_beats", 32'(bus.dma_req_beats), v.exp_beats);
    chk("wsen_pre", 32'(bus.w_s_en), 0);
    bus.dma_req_ready = 1'b1;
    step();
    bus.dma_req_ready = 1'b0;
    chk("req_drop", 32'(bus.dma_req_valid), 0);
    chk("wsen_on", 32'(bus.w_s_en), 1);
    send_beats(v.n_sent, 1'b1);
    chk("err_beats", 32'(bus.err_beats), v.exp_err);
    step();
    rotate(v.blocks_1 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   req_cyc;
    int   done_cyc;
    logic rdy;
    vec_t v;

    vecs[0] = '{k_1: 2, cin_1: 3,    blocks_1: 0,  n_sent: 34,   exp_beats: 34,   exp_err: 0};
    vecs[1] = '{k_1: 0, cin_1: 7,    blocks_1: 4,  n_sent: 22,   exp_beats: 22,   exp_err: 0};
    vecs[2] = '{k_1: 2, cin_1: 3,    blocks_1: 0,  n_sent: 33,   exp_beats: 34,   exp_err: 1};
    vecs[3] = '{k_1: 0, cin_1: 0,    blocks_1: 1,  n_sent: 15,   exp_beats: 15,   exp_err: 1};
    vecs[4] = '{k_1: 1, cin_1: 1023, blocks_1: 31, n_sent: 2070, exp_beats: 2070, exp_err: 1};

    bus.cmd_valid = 0; bus.cmd_k_1 = '0; bus.cmd_cin_1 = '0; bus.cmd_blocks_1 = '0;
    bus.dma_req_ready = 0;
    bus.w_s_tvalid = 0; bus.w_s_tready = 0; bus.w_s_tlast = 0;
    bus.w_m_tvalid = 0; bus.w_m_tready = 0; bus.w_m_tlast = 0;

    #12;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_req_valid", 32'(bus.dma_req_valid), 0);
    chk("rst_req_beats", 32'(bus.dma_req_beats), 0);
    chk("rst_wsen", 32'(bus.w_s_en), 0);
    chk("rst_done", 32'(bus.layer_done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err_beats), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    chk("post_rst_ready", 32'(bus.cmd_ready), 1);

    // stray traffic while idle must be ignored
    bus.w_s_tvalid = 1; bus.w_s_tready = 1; bus.w_s_tlast = 1;
    bus.w_m_tvalid = 1; bus.w_m_tready = 1; bus.w_m_tlast = 1;
    step();
    bus.w_s_tvalid = 0; bus.w_s_tready = 0; bus.w_s_tlast = 0;
    bus.w_m_tvalid = 0; bus.w_m_tready = 0; bus.w_m_tlast = 0;
    chk("idle_wsen", 32'(bus.w_s_en), 0);
    chk("idle_mlast", 32'(bus.layer_done), 0);
    step();
    chk("idle_err", 32'(bus.err_beats), 0);
    chk("idle_busy", 32'(bus.busy), 0);

    for (int i = 0; i < 5; i++) run_layer(vecs[i]);

    // back-to-back layers with the output side throttled
    do_cmd(0, 0, 1);
    take_req(15);
    send_beats(15, 1'b1);
    step();
    bus.cmd_k_1 = 2'd0; bus.cmd_cin_1 = 10'd1; bus.cmd_blocks_1 = 5'd0;
    bus.cmd_valid = 1'b1;
    req_cyc = -1;
    done_cyc = -1;
    for (int i = 0; i < 40 && (req_cyc < 0 || done_cyc < 0); i++) begin
      bus.w_m_tvalid = (i == 3 || i == 7);
      bus.w_m_tready = (i == 3 || i == 7);
      bus.w_m_tlast  = (i == 3 || i == 7);
      rdy = bus.cmd_ready;
      step();
      if (rdy) bus.cmd_valid = 1'b0;
      bus.w_m_tvalid = 0; bus.w_m_tready = 0; bus.w_m_tlast = 0;
      if (bus.layer_done && done_cyc < 0) done_cyc = i;
      if (bus.dma_req_valid && req_cyc < 0) req_cyc = i;
    end
    bus.cmd_valid = 1'b0;
    if (req_cyc < 0 || done_cyc < 0) timeout("throttle");
    chk("throttle_done_cyc", 32'(done_cyc), 7);
`ifdef WEIGHT_SCHED_PREFETCH_EN
    chk("prefetch_req_before_done", 32'(req_cyc < done_cyc), 1);
`else
    chk("serial_req_after_done", 32'(req_cyc > done_cyc), 1);
`endif
    take_req(16);
    send_beats(16, 1'b1);
    step();
    rotate(1);

`ifdef WEIGHT_SCHED_PREFETCH_EN
    // final rotation tlast and the prefetched load tlast land on the same edge
    do_cmd(0, 0, 0);
    take_req(15);
    send_beats(15, 1'b1);
    step();
    do_cmd(0, 0, 0);
    take_req(15);
    send_beats(14, 1'b0);
    bus.w_s_tvalid = 1; bus.w_s_tready = 1; bus.w_s_tlast = 1;
    bus.w_m_tvalid = 1; bus.w_m_tready = 1; bus.w_m_tlast = 1;
    step();
    bus.w_s_tvalid = 0; bus.w_s_tready = 0; bus.w_s_tlast = 0;
    bus.w_m_tvalid = 0; bus.w_m_tready = 0; bus.w_m_tlast = 0;
    chk("coin_done", 32'(bus.layer_done), 1);
    chk("coin_wsen", 32'(bus.w_s_en), 0);
    step();
    chk("coin_gap", 32'(bus.layer_done), 0);
    rotate(1);
`endif

    // reset in the middle of a load
    do_cmd(2, 3, 0);
    take_req(w_beats(2, 3, BEATS_CONFIG_3X3_1, BEATS_CONFIG_1X1_1));
    send_beats(10, 1'b0);
    chk("mid_wsen", 32'(bus.w_s_en), 1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_wsen", 32'(bus.w_s_en), 0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_err", 32'(bus.err_beats), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    step();
    v = '{k_1: 2, cin_1: 3, blocks_1: 0, n_sent: 34, exp_beats: 34, exp_err: 0};
    run_layer(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
